// File: rtl/muldiv_seq_if.sv
// Issue/return bundle between the execute stage and muldiv_seq.
// Handshake: enable is sampled only while the unit is idle. ready pulses for one cycle with result valid. busy holds the pipeline while an op iterates.
interface muldiv_seq_if #(
    parameter int XLEN = 32
) ();
    logic            enable;
    logic [7:0]      op;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            clear;
    logic [XLEN-1:0] result;
    logic            ready;
    logic            busy;
    logic [1:0]      fsm_state;

    modport master (
        output enable, op, rdata1, rdata2, clear,
        input  result, ready, busy, fsm_state
    );

    modport slave (
        input  enable, op, rdata1, rdata2, clear,
        output result, ready, busy, fsm_state
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider, XLEN iterations.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle array multiply.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_seq_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]      op_q;
    logic [XLEN-1:0] opnd;    // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi;      // product high word / partial remainder
    logic [XLEN-1:0] lo;      // multiplier shifting out / quotient shifting in
    logic [XLEN-1:0] res_q;
    logic            neg_lo;  // negate product or quotient
    logic            neg_hi;  // negate remainder

    // Issue-time decode
    logic            legal, is_mul, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        legal    = (bus.op != 8'd0) && ((bus.op & (bus.op - 8'd1)) == 8'd0);
        is_mul   = |bus.op[3:0];
        sgn1     = bus.op[1] | bus.op[2] | bus.op[4] | bus.op[6];
        sgn2     = bus.op[1] | bus.op[4] | bus.op[6];
        neg1     = sgn1 & bus.rdata1[XLEN-1];
        neg2     = sgn2 & bus.rdata2[XLEN-1];
        mag1     = neg1 ? -bus.rdata1 : bus.rdata1;
        mag2     = neg2 ? -bus.rdata2 : bus.rdata2;
        div_zero = (bus.rdata2 == '0);
        div_ovf  = (bus.op[4] | bus.op[6]) &&
                   (bus.rdata1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (bus.rdata2 == '1);
    end

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending to 2*XLEN makes the unsigned low product equal the signed 33x33 one.
    logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fm_a     = {{XLEN{sgn1 & bus.rdata1[XLEN-1]}}, bus.rdata1};
        fm_b     = {{XLEN{sgn2 & bus.rdata2[XLEN-1]}}, bus.rdata2};
        fm_p     = fm_a * fm_b;
        fast_res = bus.op[0] ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
`endif

    // Per-iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        rem_sh   = {hi, lo[XLEN-1]};
        rem_ge   = (rem_sh >= {1'b0, opnd});
        rem_sub  = rem_sh[XLEN-1:0] - opnd;
        prod     = {hi, lo};
        prod_fix = neg_lo ? -prod : prod;
        quo_fix  = neg_lo ? -lo : lo;
        rem_fix  = neg_hi ? -hi : hi;
        if (op_q[0])
            fix_res = prod_fix[XLEN-1:0];
        else if (|op_q[3:1])
            fix_res = prod_fix[2*XLEN-1:XLEN];
        else if (|op_q[5:4])
            fix_res = quo_fix;
        else
            fix_res = rem_fix;
    end

    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            res_q  <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        op_q <= bus.op;
                        cnt  <= '0;
                        if (!legal) begin
                            res_q <= '0;
                            state <= S_DONE;
                        end else if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                            res_q <= fast_res;
                            state <= S_DONE;
`else
                            opnd   <= mag1;
                            hi     <= '0;
                            lo     <= mag2;
                            neg_lo <= neg1 ^ neg2;
                            state  <= S_EXEC;
`endif
                        end else if (div_zero) begin
                            res_q <= (bus.op[4] | bus.op[5]) ? '1 : bus.rdata1;
                            state <= S_DONE;
                        end else if (div_ovf) begin
                            res_q <= bus.op[4] ? {1'b1, {(XLEN-1){1'b0}}} : '0;
                            state <= S_DONE;
                        end else begin
                            opnd   <= mag2;
                            hi     <= '0;
                            lo     <= mag1;
                            neg_lo <= neg1 ^ neg2;
                            neg_hi <= neg1;
                            state  <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (|op_q[3:0]) begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end else if (rem_ge) begin
                        hi <= rem_sub;
                        lo <= {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi <= rem_sh[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b0};
                    end
                    if (cnt == CNT_W'(XLEN - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    res_q <= fix_res;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.result    = (state == S_DONE) ? res_q : '0;
    assign bus.ready     = (state == S_DONE);
    assign bus.busy      = (state == S_EXEC) || (state == S_FIX);
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq with a scoreboard of expected results and ready cycles.
module tb_muldiv_seq;
    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [XLEN-1:0] exp_q[$];
    int              exp_cyc_q[$];
    string           name_q[$];

    muldiv_seq_if #(.XLEN(XLEN)) bus ();

    muldiv_seq #(.XLEN(XLEN), .CNT_W(5)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and cycle counter (cyc = number of rising edges seen so far)
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ready pulse
    logic [XLEN-1:0] mon_exp;
    int              mon_cyc;
    string           mon_name;

    always @(negedge clk) begin
        if (!reset && bus.ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got pulse with result %h at cycle %0d, required none",
                         bus.result, cyc);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_cyc  = exp_cyc_q.pop_front();
                mon_name = name_q.pop_front();
                check({mon_name, "_result"}, bus.result, mon_exp);
                check({mon_name, "_ready_cycle"}, cyc, mon_cyc);
            end
        end
    end

    // Driver tasks
    task automatic push_exp(input string name, input logic [31:0] e, input int at_cyc);
        name_q.push_back(name);
        exp_q.push_back(e);
        exp_cyc_q.push_back(at_cyc);
    endtask

    task automatic drive(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.enable = 1'b1;
        bus.op     = o;
        bus.rdata1 = a;
        bus.rdata2 = b;
    endtask

    task automatic wait_ready(input string name, output int busy_cnt);
        int n;
        n = 0;
        busy_cnt = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.ready) break;
            if (bus.busy) busy_cnt++;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready in 200 cycles, required a ready pulse", name);
            exp_q.delete();
            exp_cyc_q.delete();
            name_q.delete();
        end
    endtask

    // Issue at the next edge (accept edge A); ready is seen at the negedge where cyc = A + lat - 1.
    task automatic run_op(input string name, input logic [7:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input int lat);
        int bc;
        @(posedge clk); #1;
        drive(o, a, b);
        push_exp(name, e, cyc + lat);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        wait_ready(name, bc);
        check({name, "_busy_cycles"}, bc, (lat == 34) ? 33 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        bus.enable = 1'b0;
        bus.op     = 8'h00;
        bus.rdata1 = '0;
        bus.rdata2 = '0;
        bus.clear  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_result", bus.result, 32'h0);
        check("reset_ready", {31'b0, bus.ready}, 32'h0);
        check("reset_busy", {31'b0, bus.busy}, 32'h0);
        check("reset_state", {30'b0, bus.fsm_state}, 32'h0);
        reset = 1'b0;

        // Multiplies
        run_op("mul",    8'h01, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run_op("mulhu",  8'h08, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run_op("mulh",   8'h02, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run_op("mulhsu", 8'h04, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);

        // Divides
        run_op("div",    8'h10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT);
        run_op("rem",    8'h40, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_LAT);
        run_op("divu",   8'h20, 32'd100,      32'd7, 32'd14,       DIV_LAT);
        run_op("remu",   8'h80, 32'd100,      32'd7, 32'd2,        DIV_LAT);

        // Special cases and illegal op
        run_op("divu_by0", 8'h20, 32'h1234,     32'h0,        32'hFFFFFFFF, 1);
        run_op("rem_by0",  8'h40, 32'h1234,     32'h0,        32'h1234,     1);
        run_op("div_ovf",  8'h10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",  8'h40, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
        run_op("illegal",  8'h03, 32'd5,        32'd6,        32'h0,        1);

        // Clear at count 10, then a div issued in the following cycle
        @(posedge clk); #1;
        drive(8'h10, 32'd1000, 32'd7);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_clear_busy", {31'b0, bus.busy}, 32'h1);
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        check("clear_state", {30'b0, bus.fsm_state}, 32'h0);
        check("clear_busy", {31'b0, bus.busy}, 32'h0);
        drive(8'h10, 32'd9, 32'd3);
        push_exp("div_after_clear", 32'd3, cyc + DIV_LAT);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        wait_ready("div_after_clear", bc);

        // Reset mid-multiply discards the operation
        @(posedge clk); #1;
        drive(8'h01, 32'd3, 32'd5);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_result", bus.result, 32'h0);
        check("midreset_ready", {31'b0, bus.ready}, 32'h0);
        check("midreset_busy", {31'b0, bus.busy}, 32'h0);
        reset = 1'b0;

        // Back-to-back with enable held: second op accepted in the IDLE cycle after DONE
        @(posedge clk); #1;
        drive(8'h08, 32'hFFFFFFFF, 32'hFFFFFFFF);
        push_exp("b2b_mulhu", 32'hFFFFFFFE, cyc + MUL_LAT);
        wait_ready("b2b_mulhu", bc);
        drive(8'h20, 32'd100, 32'd7);
        push_exp("b2b_divu", 32'd14, cyc + 2 + DIV_LAT - 1);
        wait_ready("b2b_divu", bc);
        bus.enable = 1'b0;

        repeat (40) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
